usb_hid_supervisor: RTL

Connection supervisor for usb_hid_host. It owns the core's reset input and sequences the core through power-on reset, enumeration and steady polling. It detects dead links (conerr, disconnect, report starvation) and re-resets the core with exponential backoff, latching a fault after repeated failures. It sits between the board top level and usb_hid_host, in the usbclk domain.

---
 rtl/usb_hid_supervisor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/usb_hid_supervisor.sv
// Connection supervisor for usb_hid_host: sequences core reset, enumeration and polling,
// re-resets dead links with exponential backoff and latches FAULT after repeated failures.
module usb_hid_supervisor #(
    parameter int unsigned RST_CYCLES     = 120000,
    parameter int unsigned ENUM_CYCLES    = 24000000,
    parameter int unsigned TIMEOUT_CYCLES = 6000000,
    parameter int unsigned BACKOFF_BASE   = 600000,
    parameter int unsigned MAX_EXP        = 3,
    parameter int unsigned MAX_FAILS      = 8
) (
    input  logic        usbclk,
    input  logic        usbrst_n,
    input  logic        enable,
    input  logic        retry_now,
    output logic        core_rst_n,
    input  logic [1:0]  core_typ,
    input  logic        core_report,
    input  logic        core_conerr,
    output logic [2:0]  state,
    output logic        dev_ready,
    output logic [1:0]  dev_typ,
    output logic [3:0]  fail_cnt,
    output logic [7:0]  retry_cnt,
    output logic [15:0] report_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_ENUM = 3'd2,
        ACTIVE    = 3'd3,
        BACKOFF   = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t      cur_st, nxt_st;
    logic [31:0] timer;
    logic [4:0]  exp_q, exp_d;
    logic [31:0] backoff_len;
    logic        fail;
    logic [3:0]  fail_inc;
    logic        core_rst_n_d, dev_ready_d;
    logic [1:0]  dev_typ_d;
    logic [3:0]  fail_cnt_d;
    logic [7:0]  retry_cnt_d;
    logic [15:0] report_cnt_d;

    assign state       = cur_st;
    assign backoff_len = 32'(BACKOFF_BASE) << exp_q;
    assign fail_inc    = (fail_cnt >= 4'(MAX_FAILS)) ? fail_cnt : fail_cnt + 4'd1;

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            cur_st <= IDLE;
            timer  <= '0;
        end else begin
            cur_st <= nxt_st;
            if (nxt_st != cur_st || (cur_st == ACTIVE && core_report))
                timer <= '0;
            else
                timer <= timer + 32'd1;
        end
    end

    // conerr is held off for two cycles after core reset release; it wins over typ
    always_comb begin
        fail = 1'b0;
        case (cur_st)
            WAIT_ENUM: fail = (core_conerr && timer >= 32'd2) ||
                              (core_typ == 2'd0 && timer == 32'(ENUM_CYCLES - 1));
            ACTIVE:    fail = core_typ == 2'd0 || core_conerr ||
                              (timer == 32'(TIMEOUT_CYCLES - 1) && !core_report);
            default:   fail = 1'b0;
        endcase
    end

    always_comb begin
        nxt_st = cur_st;
        if (!enable) begin
            nxt_st = IDLE;
        end else begin
            case (cur_st)
                IDLE:      nxt_st = RESET;
                RESET:     if (timer == 32'(RST_CYCLES - 1)) nxt_st = WAIT_ENUM;
                WAIT_ENUM, ACTIVE: begin
                    if (fail)
                        nxt_st = (fail_inc == 4'(MAX_FAILS)) ? FAULT : BACKOFF;
                    else if (cur_st == WAIT_ENUM && core_typ != 2'd0)
                        nxt_st = ACTIVE;
                end
                BACKOFF:   if (retry_now || timer == backoff_len - 32'd1) nxt_st = RESET;
                FAULT:     if (retry_now) nxt_st = RESET;
                default:   nxt_st = IDLE;
            endcase
        end
    end

    always_comb begin
        core_rst_n_d = (nxt_st == WAIT_ENUM) || (nxt_st == ACTIVE);
        dev_ready_d  = (nxt_st == ACTIVE);
        dev_typ_d    = '0;
        if (nxt_st == ACTIVE)
            dev_typ_d = (cur_st == ACTIVE) ? dev_typ : core_typ;
        fail_cnt_d   = fail_cnt;
        retry_cnt_d  = retry_cnt;
        exp_d        = exp_q;
        report_cnt_d = report_cnt;
        if (cur_st == ACTIVE && core_report && report_cnt != 16'hFFFF)
            report_cnt_d = report_cnt + 16'd1;
        if (!enable) begin
            fail_cnt_d = '0;
            exp_d      = '0;
        end else if (fail) begin
            fail_cnt_d = fail_inc;
            if (retry_cnt != 8'hFF)
                retry_cnt_d = retry_cnt + 8'd1;
        end else if ((cur_st == WAIT_ENUM && nxt_st == ACTIVE) ||
                     (cur_st == FAULT && retry_now)) begin
            fail_cnt_d = '0;
            exp_d      = '0;
        end else if (cur_st == BACKOFF && !retry_now && timer == backoff_len - 32'd1) begin
            exp_d = (exp_q < 5'(MAX_EXP)) ? exp_q + 5'd1 : 5'(MAX_EXP);
        end
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            core_rst_n <= 1'b0;
            dev_ready  <= 1'b0;
            dev_typ    <= '0;
            fail_cnt   <= '0;
            retry_cnt  <= '0;
            report_cnt <= '0;
            exp_q      <= '0;
        end else begin
            core_rst_n <= core_rst_n_d;
            dev_ready  <= dev_ready_d;
            dev_typ    <= dev_typ_d;
            fail_cnt   <= fail_cnt_d;
            retry_cnt  <= retry_cnt_d;
            report_cnt <= report_cnt_d;
            exp_q      <= exp_d;
        end
    end

endmodule
